// File: rtl/buf_dist_pkg.sv
// buf_dist_pkg: shared types and constants for the frame distributor.
// The stored word layout fixes the data width, so W of buf_dist must equal DATA_W.
package buf_dist_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  // one buffer word: data plus end-of-frame marker
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_t;
endpackage

// File: rtl/buf_dist_if.sv
// buf_dist_if: framed source inputs and per-channel consumer outputs.
// master = source/consumer side, slave = buf_dist.
interface buf_dist_if #(
  parameter int W = 8,
  parameter int N = 2
);
  import buf_dist_pkg::*;
  localparam int SW = $clog2(N + 1);

  logic                      v_i;
  logic [W-1:0]              d_i;
  logic [SW-1:0]             sel_i;
  logic [N-1:0]              rdy;
  logic [N-1:0]              v_o;
  logic [N-1:0][W-1:0]       d_o;
  logic [N-1:0]              eof;
  logic [N-1:0]              avl;
  logic                      drop;
  logic [N-1:0][CNT_W-1:0]   drop_cnt;

  modport master (
    output v_i, d_i, sel_i, rdy,
    input  v_o, d_o, eof, avl, drop, drop_cnt
  );
  modport slave (
    input  v_i, d_i, sel_i, rdy,
    output v_o, d_o, eof, avl, drop, drop_cnt
  );
endinterface

// File: rtl/buf_cmt_fifo.sv
// buf_cmt_fifo: one channel's frame buffer. Words land at a speculative
// pointer and become visible only when the frame's last word commits; an
// overflowing frame is rolled back. A read FSM drains one whole frame per request.
module buf_cmt_fifo
  import buf_dist_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int D = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_last,
  input  logic [W-1:0] wr_data,
  input  logic         rdy,
  output logic         v_o,
  output logic [W-1:0] d_o,
  output logic         eof,
  output logic         avl,
  output logic         drop
);
  localparam int CW = $clog2(2**D + 1);

  word_t          mem [2**D];
  logic [D-1:0]   wc, ws, rp, ws_inc;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           ovf, full, wr_ok, cmt, dec, issue, fin;
  state_t         state;
  word_t          rd_w;

  // one slot is always left free so a full buffer never looks empty
  assign ws_inc  = ws + 1'b1;
  assign full    = (ws_inc == rp);
  assign wr_ok   = wr_en & ~ovf & ~full;
  assign cmt     = wr_en & wr_last & ~ovf & ~full;
  assign drop    = wr_en & wr_last & (ovf | full);
  assign rd_w    = mem[rp];
  assign issue   = (state == RD) & ~fin;
  assign dec     = (state == RD) & eof;
  assign cnt_nxt = cnt + CW'(cmt) - CW'(dec);

  // word store; only the uncommitted region past wc is ever written
  always_ff @(posedge clk) begin
    if (wr_ok) mem[ws] <= '{last: wr_last, data: wr_data};
  end

  // write pointers: advance speculatively, commit on last, roll back on overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wc  <= '0;
      ws  <= '0;
      ovf <= 1'b0;
    end else if (wr_en) begin
      if (wr_last) begin
        if (ovf || full) ws <= wc;
        else begin
          ws <= ws_inc;
          wc <= ws_inc;
        end
        ovf <= 1'b0;
      end else if (ovf || full) ovf <= 1'b1;
      else ws <= ws_inc;
    end
  end

  // read FSM: issue words until the last flag, leave RD once eof is out
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fin   <= 1'b0;
      rp    <= '0;
      v_o   <= 1'b0;
      d_o   <= '0;
      eof   <= 1'b0;
      cnt   <= '0;
      avl   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      avl <= (cnt_nxt != '0);
      v_o <= issue;
      eof <= issue & rd_w.last;
      if (issue) begin
        d_o <= rd_w.data;
        rp  <= rp + 1'b1;
        if (rd_w.last) fin <= 1'b1;
      end
      case (state)
        IDLE: if (rdy && cnt != '0) state <= RD;
        RD: if (eof) begin
          state <= IDLE;
          fin   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/buf_dist.sv
// buf_dist: steers each input frame to one of N committed frame buffers
// chosen by sel_i on the frame's first word. Out-of-range selects and
// overflowing frames are discarded with a one-cycle drop pulse.
// Optional BUF_DIST_STAT_EN adds saturating per-channel discard counters.
module buf_dist
  import buf_dist_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int N = 2,
  parameter int D = 7
) (
  input logic       clk,
  input logic       rst,
  buf_dist_if.slave bus
);
  localparam int SW = $clog2(N + 1);

  logic          h_v;
  logic [W-1:0]  h_d;
  logic [SW-1:0] f_sel;
  logic          frm_end, bad_sel;
  logic [N-1:0]  ch_drop;

  // one-word input holding register; destination latched on the first word
  always_ff @(posedge clk) begin
    if (rst) begin
      h_v   <= 1'b0;
      h_d   <= '0;
      f_sel <= '0;
    end else begin
      h_v <= bus.v_i;
      h_d <= bus.d_i;
      if (bus.v_i && !h_v) f_sel <= bus.sel_i;
    end
  end

  // the held word is the frame's last when v_i has already dropped
  assign frm_end  = h_v & ~bus.v_i;
  assign bad_sel  = (int'(f_sel) >= N);
  assign bus.drop = frm_end & (bad_sel | (|ch_drop));

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic wr_en;
    assign wr_en = h_v & (int'(f_sel) == i);

    buf_cmt_fifo #(.W(W), .D(D)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_last (~bus.v_i),
      .wr_data (h_d),
      .rdy     (bus.rdy[i]),
      .v_o     (bus.v_o[i]),
      .d_o     (bus.d_o[i]),
      .eof     (bus.eof[i]),
      .avl     (bus.avl[i]),
      .drop    (ch_drop[i])
    );

`ifdef BUF_DIST_STAT_EN
    logic [CNT_W-1:0] cnt_q;
    // saturating count of frames this channel discarded
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else if (ch_drop[i] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
    assign bus.drop_cnt[i] = cnt_q;
`else
    assign bus.drop_cnt[i] = '0;
`endif
  end
endmodule

// File: tb/tb_buf_dist.sv
// tb_buf_dist: random and directed frames against a word-queue model of
// each channel (capacity 2^D-1 words, whole-frame commit, in-order delivery).
module tb_buf_dist;
  import buf_dist_pkg::*;
  localparam int W   = 8;
  localparam int N   = 2;
  localparam int D   = 4;
  localparam int SW  = $clog2(N + 1);
  localparam int CAP = 2**D - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buf_dist_if #(.W(W), .N(N)) bus ();
  buf_dist #(.W(W), .N(N), .D(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [8:0]          mq [N][$];
  int                  nfr [N];
  logic [N-1:0][15:0]  dcnt;
  logic [7:0]          fbuf [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] exp_avl();
    logic [N-1:0] a;
    a = '0;
    for (int i = 0; i < N; i++) a[i] = (nfr[i] != 0);
    return a;
  endfunction

  task automatic fill_rand(input int len);
    for (int k = 0; k < len; k++) fbuf[k] = 8'($urandom);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      nfr[i] = 0;
    end
    dcnt = '0;
  endtask

  task automatic send_frame(input int ch, input int len);
    bit dr;
    if (ch >= N) dr = 1'b1;
    else dr = (len > CAP - mq[ch].size());
    tick();
    for (int k = 0; k < len; k++) begin
      bus.v_i   = 1'b1;
      bus.d_i   = fbuf[k];
      bus.sel_i = (k == 0) ? SW'(ch) : SW'($urandom_range(0, 3));
      tick();
    end
    bus.v_i = 1'b0;
    bus.d_i = '0;
    mid();
    checks++;
    if (bus.drop !== dr) begin
      errors++;
      $display("FAIL drop ch=%0d len=%0d: got %b exp %b", ch, len, bus.drop, dr);
    end
    checks++;
    if (bus.avl !== exp_avl()) begin
      errors++;
      $display("FAIL avl_early ch=%0d: got %b exp %b", ch, bus.avl, exp_avl());
    end
    if (!dr) begin
      for (int k = 0; k < len; k++) mq[ch].push_back({(k == len - 1), fbuf[k]});
      nfr[ch]++;
    end else if (ch < N) begin
`ifdef BUF_DIST_STAT_EN
      if (dcnt[ch] != 16'hFFFF) dcnt[ch] = dcnt[ch] + 16'd1;
`endif
    end
    tick();
    mid();
    checks++;
    if (bus.avl !== exp_avl()) begin
      errors++;
      $display("FAIL avl ch=%0d: got %b exp %b", ch, bus.avl, exp_avl());
    end
    checks++;
    if (bus.drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_width ch=%0d: got %b exp 0", ch, bus.drop);
    end
    checks++;
    if (bus.drop_cnt !== dcnt) begin
      errors++;
      $display("FAIL drop_cnt: got %h exp %h", bus.drop_cnt, dcnt);
    end
  endtask

  task automatic read_frame(input int ch);
    logic [8:0] w;
    tick();
    bus.rdy[ch] = 1'b1;
    tick();
    bus.rdy[ch] = 1'b0;
    mid();
    checks++;
    if (bus.v_o[ch] !== 1'b0) begin
      errors++;
      $display("FAIL rd_early ch=%0d: got v_o=%b exp 0", ch, bus.v_o[ch]);
    end
    tick();
    do begin
      mid();
      w = mq[ch].pop_front();
      checks++;
      if (bus.v_o[ch] !== 1'b1 || bus.d_o[ch] !== w[7:0] || bus.eof[ch] !== w[8]) begin
        errors++;
        $display("FAIL rd_word ch=%0d: got v=%b d=%h eof=%b exp v=1 d=%h eof=%b",
                 ch, bus.v_o[ch], bus.d_o[ch], bus.eof[ch], w[7:0], w[8]);
      end
      tick();
    end while (!w[8] && mq[ch].size() != 0);
    nfr[ch]--;
    mid();
    checks++;
    if (bus.v_o[ch] !== 1'b0 || bus.avl !== exp_avl()) begin
      errors++;
      $display("FAIL rd_end ch=%0d: got v_o=%b avl=%b exp v_o=0 avl=%b",
               ch, bus.v_o[ch], bus.avl, exp_avl());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.v_i = 1'b0;
    bus.d_i = '0;
    bus.sel_i = '0;
    bus.rdy = '0;
    clear_model();
    tick();
    tick();
    mid();
    checks++;
    if ({bus.v_o, bus.eof, bus.avl, bus.drop} !== '0 || bus.d_o !== '0 || bus.drop_cnt !== '0) begin
      errors++;
      $display("FAIL reset: got v_o=%b eof=%b avl=%b drop=%b d_o=%h cnt=%h exp all 0",
               bus.v_o, bus.eof, bus.avl, bus.drop, bus.d_o, bus.drop_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fbuf[0] = 8'h11;
    fbuf[1] = 8'h22;
    fbuf[2] = 8'h33;
    send_frame(1, 3);
    read_frame(1);
  endtask

  task automatic test_rdy_empty();
    tick();
    bus.rdy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      mid();
      checks++;
      if (bus.v_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL rdy_empty: got v_o=%b exp 0", bus.v_o[0]);
      end
    end
    bus.rdy[0] = 1'b0;
  endtask

  task automatic test_overflow();
    fill_rand(20); send_frame(0, 20);
    fill_rand(5);  send_frame(0, 5);
    read_frame(0);
    fill_rand(15); send_frame(0, 15);
    read_frame(0);
    fill_rand(16); send_frame(0, 16);
    fill_rand(2);  send_frame(0, 2);
    read_frame(0);
  endtask

  task automatic test_bad_sel();
    fill_rand(4);
    send_frame(2, 4);
  endtask

  task automatic test_commit_eof();
    fill_rand(3);
    send_frame(0, 3);
    fill_rand(4);
    fork
      read_frame(0);
      send_frame(0, 4);
    join
    read_frame(0);
  endtask

  task automatic test_wrap();
    fill_rand(7);
    send_frame(0, 7);
    for (int i = 0; i < 10; i++) begin
      fill_rand(7);
      send_frame(0, 7);
      read_frame(0);
    end
    read_frame(0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      fill_rand(18);
      send_frame(int'($urandom_range(0, 2)), int'($urandom_range(1, 18)));
      for (int c = 0; c < N; c++)
        if (nfr[c] > 0 && $urandom_range(0, 1) == 1) read_frame(c);
    end
    for (int c = 0; c < N; c++)
      while (nfr[c] > 0) read_frame(c);
  endtask

  task automatic test_mid_reset();
    fill_rand(4);
    send_frame(1, 4);
    tick();
    bus.rdy[1] = 1'b1;
    tick();
    bus.rdy[1] = 1'b0;
    bus.v_i = 1'b1; bus.sel_i = '0; bus.d_i = 8'hA1;
    tick();
    bus.d_i = 8'hA2;
    mid();
    checks++;
    if (bus.v_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_read: got v_o=%b exp 1", bus.v_o[1]);
    end
    tick();
    bus.d_i = 8'hA3;
    rst = 1'b1;
    tick();
    bus.v_i = 1'b0;
    mid();
    checks++;
    if ({bus.v_o, bus.eof, bus.avl, bus.drop} !== '0 || bus.d_o !== '0 || bus.drop_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v_o=%b eof=%b avl=%b drop=%b d_o=%h cnt=%h exp all 0",
               bus.v_o, bus.eof, bus.avl, bus.drop, bus.d_o, bus.drop_cnt);
    end
    rst = 1'b0;
    clear_model();
    tick();
    mid();
    checks++;
    if (bus.drop !== 1'b0 || bus.avl !== '0) begin
      errors++;
      $display("FAIL post_reset: got drop=%b avl=%b exp 0", bus.drop, bus.avl);
    end
    fill_rand(2);
    send_frame(0, 2);
    read_frame(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rdy_empty();
    test_overflow();
    test_bad_sel();
    test_commit_eof();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
